// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the fetch PC, drives the instruction ROM
// address and fills the IF/ID pipeline register. A fetch from outside the
// ROM window, or from a misaligned address, parks the stage in FAULT until
// a redirect arrives.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'hBFC00000,
    parameter int unsigned MEM_BYTES = 4096,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        RUN,
        FAULT
    } state_e;

    // One bit wider than the PC so a window ending at 2^32 does not wrap.
    localparam logic [32:0] WIN_END = {1'b0, RESET_PC} + 33'(MEM_BYTES);

    state_e      state_q, state_d;
    logic [31:0] pcF_q, pcF_d;
    logic [31:0] instrD_q, instrD_d;
    logic [31:0] pcD_q, pcD_d;
    logic [31:0] pcPlus4D_q, pcPlus4D_d;
    logic        validD_q, validD_d;
    logic [31:0] faultPc_q, faultPc_d;
    logic [31:0] fetchCount_q, fetchCount_d;

    logic [31:0] pcPlus4F;
    logic        fetchLegal;

    // Sequential PC and the legality of fetching from the current PC.
    always_comb begin
        pcPlus4F   = pcF_q + 32'd4;
        fetchLegal = (pcF_q[1:0] == 2'b00) && (pcF_q >= RESET_PC) && ({1'b0, pcF_q} < WIN_END);
    end

    // Next-state logic for the fetch PC, the IF/ID register and the fault FSM.
    always_comb begin
        state_d      = state_q;
        pcF_d        = pcF_q;
        instrD_d     = instrD_q;
        pcD_d        = pcD_q;
        pcPlus4D_d   = pcPlus4D_q;
        validD_d     = validD_q;
        faultPc_d    = faultPc_q;
        fetchCount_d = fetchCount_q;

        unique case (state_q)
            RUN: begin
                if (redirect_en) begin
                    pcF_d = redirect_pc;
                end else if (!stall_f) begin
                    pcF_d = pcPlus4F;
                end

                if (flush_d) begin
                    instrD_d = NOP_INSTR;
                    validD_d = 1'b0;
                end else if (!stall_d) begin
                    if (fetchLegal) begin
                        instrD_d     = imem_rd;
                        pcD_d        = pcF_q;
                        pcPlus4D_d   = pcPlus4F;
                        validD_d     = 1'b1;
                        fetchCount_d = fetchCount_q + 32'd1;
                    end else begin
                        instrD_d  = NOP_INSTR;
                        validD_d  = 1'b0;
                        faultPc_d = pcF_q;
                        state_d   = FAULT;
                    end
                end
            end

            FAULT: begin
                if (redirect_en) begin
                    pcF_d   = redirect_pc;
                    state_d = RUN;
                end

                if (flush_d || !stall_d) begin
                    instrD_d = NOP_INSTR;
                    validD_d = 1'b0;
                end
            end

            default: state_d = RUN;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pcF_q        <= RESET_PC;
            instrD_q     <= NOP_INSTR;
            pcD_q        <= 32'd0;
            pcPlus4D_q   <= 32'd0;
            validD_q     <= 1'b0;
            faultPc_q    <= 32'd0;
            fetchCount_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pcF_q        <= pcF_d;
            instrD_q     <= instrD_d;
            pcD_q        <= pcD_d;
            pcPlus4D_q   <= pcPlus4D_d;
            validD_q     <= validD_d;
            faultPc_q    <= faultPc_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    assign imem_addr   = pcF_q;
    assign instr_d     = instrD_q;
    assign pc_d        = pcD_q;
    assign pcplus4_d   = pcPlus4D_q;
    assign valid_d     = validD_q;
    assign fault       = (state_q == FAULT);
    assign fault_pc    = faultPc_q;
    assign fetch_count = fetchCount_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a long
// randomized run, all compared against a cycle-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'hBFC00000;
    localparam int unsigned MEM_BYTES = 4096;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, stall_f, stall_d, flush_d, redirect_en;
    logic [31:0] redirect_pc, imem_addr, imem_rd;
    logic [31:0] instr_d, pc_d, pcplus4_d, fault_pc, fetch_count;
    logic        valid_d, fault;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference model state.
    logic [31:0] mPc, mInstr, mPcD, mPc4D, mFaultPc, mCount;
    logic        mValid, mFault;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .MEM_BYTES(MEM_BYTES),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d),
        .fault      (fault),
        .fault_pc   (fault_pc),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Address-derived ROM contents, distinct for every address.
    function automatic logic [31:0] romWord(input logic [31:0] addr);
        return addr ^ 32'hDEAD0000;
    endfunction

    assign imem_rd = romWord(imem_addr);

    function automatic bit isLegal(input logic [31:0] pc);
        longint p;
        p = longint'({32'd0, pc});
        return (pc[1:0] == 2'b00) && (p >= longint'({32'd0, RESET_PC}))
               && (p < longint'({32'd0, RESET_PC}) + longint'(MEM_BYTES));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare every visible output with the model; PC fields only matter
    // when the model says the IF/ID slot holds a real instruction.
    task automatic compareAll();
        checkOutput("imem_addr", imem_addr, mPc);
        checkOutput("valid_d", {31'd0, valid_d}, {31'd0, mValid});
        checkOutput("instr_d", instr_d, mInstr);
        checkOutput("fault", {31'd0, fault}, {31'd0, mFault});
        checkOutput("fault_pc", fault_pc, mFaultPc);
        checkOutput("fetch_count", fetch_count, mCount);
        if (mValid) begin
            checkOutput("pc_d", pc_d, mPcD);
            checkOutput("pcplus4_d", pcplus4_d, mPc4D);
        end
    endtask

    // Drive one cycle of inputs, advance the model by one edge, then compare.
    task automatic applyStimulus(input logic iRst, input logic iStallF, input logic iStallD,
                                 input logic iFlushD, input logic iRedir, input logic [31:0] iRpc);
        logic [31:0] oldPc;
        rst         = iRst;
        stall_f     = iStallF;
        stall_d     = iStallD;
        flush_d     = iFlushD;
        redirect_en = iRedir;
        redirect_pc = iRpc;
        oldPc       = mPc;
        if (iRst) begin
            mPc = RESET_PC; mInstr = NOP_INSTR; mPcD = 0; mPc4D = 0;
            mValid = 0; mFault = 0; mFaultPc = 0; mCount = 0;
        end else if (!mFault) begin
            if (iFlushD) begin
                mInstr = NOP_INSTR; mValid = 0;
            end else if (!iStallD) begin
                if (isLegal(oldPc)) begin
                    mInstr = romWord(oldPc); mPcD = oldPc; mPc4D = oldPc + 4;
                    mValid = 1; mCount = mCount + 1;
                end else begin
                    mInstr = NOP_INSTR; mValid = 0; mFault = 1; mFaultPc = oldPc;
                end
            end
            mPc = iRedir ? iRpc : (iStallF ? oldPc : oldPc + 4);
        end else begin
            if (iFlushD || !iStallD) begin
                mInstr = NOP_INSTR; mValid = 0;
            end
            if (iRedir) begin
                mPc = iRpc; mFault = 0;
            end
        end
        @(posedge clk);
        #1;
        compareAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 32'd0);
    endtask

    initial begin
        logic [31:0] target;
        int          kind;
        rst = 1; stall_f = 0; stall_d = 0; flush_d = 0; redirect_en = 0; redirect_pc = 0;
        mPc = 0; mInstr = 0; mPcD = 0; mPc4D = 0; mValid = 0; mFault = 0; mFaultPc = 0; mCount = 0;
        @(negedge clk);

        // Reset state.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 1, 32'h12345678);
        checkOutput("rst_pc_d", pc_d, 32'd0);
        checkOutput("rst_pcplus4_d", pcplus4_d, 32'd0);
        checkOutput("rst_imem_addr", imem_addr, 32'hBFC00000);

        // Sequential fetch.
        idle(4);
        checkOutput("seq_pc_d", pc_d, 32'hBFC0000C);
        checkOutput("seq_count", fetch_count, 32'd4);

        // Stall at BFC00008.
        applyStimulus(1, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("stall_addr", imem_addr, 32'hBFC00008);
        checkOutput("stall_count", fetch_count, 32'd2);
        idle(1);
        checkOutput("stall_release_pc_d", pc_d, 32'hBFC00008);

        // Redirect with simultaneous flush and stall.
        applyStimulus(0, 1, 1, 1, 1, 32'hBFC00100);
        checkOutput("flush_instr", instr_d, 32'h00000013);
        idle(1);
        checkOutput("redir_pc_d", pc_d, 32'hBFC00100);

        // Out-of-window fault and recovery.
        applyStimulus(0, 0, 0, 0, 1, 32'hBFC01000);
        idle(1);
        checkOutput("oow_fault", {31'd0, fault}, 32'd1);
        checkOutput("oow_fault_pc", fault_pc, 32'hBFC01000);
        for (int i = 0; i < 5; i++) applyStimulus(0, i[0], i[1], 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'hBFC00000);
        checkOutput("recover_fault", {31'd0, fault}, 32'd0);
        idle(1);
        checkOutput("recover_pc_d", pc_d, 32'hBFC00000);

        // Misaligned target, then window end.
        applyStimulus(0, 0, 0, 0, 1, 32'hBFC00002);
        idle(1);
        checkOutput("misalign_fault_pc", fault_pc, 32'hBFC00002);
        applyStimulus(0, 0, 0, 0, 1, 32'hBFC00FFC);
        idle(1);
        checkOutput("edge_pc_d", pc_d, 32'hBFC00FFC);
        idle(1);
        checkOutput("edge_fault_pc", fault_pc, 32'hBFC01000);

        // Reset while faulted.
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("rst_fault", {31'd0, fault}, 32'd0);
        checkOutput("rst_count", fetch_count, 32'd0);

        // Randomized run.
        for (int i = 0; i < 3000; i++) begin
            kind = $urandom_range(0, 7);
            case (kind)
                0, 1:    target = RESET_PC + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
                2:       target = RESET_PC + 32'($urandom_range(0, 4095)) | 32'd1;
                3:       target = RESET_PC + MEM_BYTES - 32'(4 * $urandom_range(1, 3));
                4:       target = $urandom;
                5:       target = RESET_PC - 32'd4;
                default: target = RESET_PC + MEM_BYTES + 32'(4 * $urandom_range(0, 3));
            endcase
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 9) == 0, target);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'hBFC00000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter MEM_BYTES, default 4096, giving the instruction ROM window size in bytes starting at RESET_PC.
REQ-003 The block SHALL have parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), used as the bubble instruction.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows (clock and reset first).
- clk  input  1  sole clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- stall_f  input  1  hold the fetch PC.
- stall_d  input  1  hold the IF/ID register.
- flush_d  input  1  replace the IF/ID contents with a bubble.
- redirect_en  input  1  load the fetch PC from redirect_pc (branch/jump taken).
- redirect_pc  input  32  redirect target byte address.
- imem_addr  output  32  byte address to the instruction ROM, which returns data combinationally.
- imem_rd  input  32  instruction word from the ROM, valid in the same cycle.
- instr_d  output  32  IF/ID instruction.
- pc_d  output  32  IF/ID PC.
- pcplus4_d  output  32  IF/ID PC+4.
- valid_d  output  1  IF/ID holds a real instruction.
- fault  output  1  fetch fault is latched.
- fault_pc  output  32  PC that caused the fault.
- fetch_count  output  32  number of valid instructions captured into IF/ID.

Function
REQ-005 imem_addr SHALL equal pc_f combinationally, with no added latency, so the instruction for pc_f is sampled at the next rising edge.
REQ-006 The block SHALL be a two-state FSM: RUN, FAULT; reset enters RUN.
REQ-007 In RUN, pc_f next-value priority SHALL be: rst > redirect_en (redirect_pc) > stall_f (hold) > pc_f+4, with 32-bit wrapping add.
REQ-008 IF/ID update priority SHALL be: rst > flush_d (instr_d=NOP_INSTR, valid_d=0, pc_d and pcplus4_d unchanged) > stall_d (hold all) > capture.
- Capture: instr_d=imem_rd, pc_d=pc_f, pcplus4_d=pc_f+4, valid_d=1.
REQ-009 flush_d and stall_d asserted together SHALL flush; redirect_en and stall_f asserted together SHALL redirect.
REQ-010 A fetch SHALL be illegal when pc_f[1:0]!=0, pc_f<RESET_PC, or pc_f>=RESET_PC+MEM_BYTES.
REQ-011 A capture in RUN with an illegal pc_f SHALL instead load a bubble into IF/ID (instr_d=NOP_INSTR, valid_d=0), set fault=1, latch fault_pc=pc_f, and go to FAULT.
- flush_d still overrides this, with no fault raised.
- When stall_d is asserted, no fault is raised.
REQ-012 In FAULT:
- pc_f SHALL hold.
- Every IF/ID capture SHALL load a bubble.
- fault and fault_pc SHALL hold.
- stall_f SHALL be ignored.
REQ-013 redirect_en in FAULT SHALL load pc_f=redirect_pc, clear fault, and return to RUN the next cycle; fault_pc SHALL retain its last value.
REQ-014 fetch_count SHALL increment by 1, wrapping at 2^32, on each edge where valid_d is loaded with 1; holds, flushes and bubbles SHALL not count.
REQ-015 A redirect to an illegal target SHALL fault on its first capture, not at redirect time.

Reset
REQ-016 On rst=1 at a rising edge, regardless of state, the block SHALL set:
- pc_f=RESET_PC, state=RUN.
- instr_d=NOP_INSTR, pc_d=0, pcplus4_d=0, valid_d=0.
- fault=0, fault_pc=0, fetch_count=0.
REQ-017 rst SHALL take priority over every other input, including mid-stall, mid-flush and in FAULT; the first capture SHALL occur on the first edge with rst=0.

Verification
REQ-018 Sequential fetch: release reset, ROM returns addr-derived words, no stalls for 4 edges -> pc_d = BFC00000, BFC00004, BFC00008, BFC0000C on successive edges, valid_d=1, fetch_count=4.
REQ-019 Stall: stall_f=stall_d=1 for 3 cycles at pc_f=BFC00008 -> imem_addr stays BFC00008, IF/ID unchanged, fetch_count frozen; after release, pc_d=BFC00008.
REQ-020 Redirect and flush in the same cycle: redirect_en=1, redirect_pc=BFC00100, flush_d=1, stall_d=1 -> next edge instr_d=00000013, valid_d=0; the edge after that pc_d=BFC00100.
REQ-021 Out-of-window fault: redirect to BFC01000 -> next capture bubble, fault=1, fault_pc=BFC01000; 5 further cycles hold state; redirect to BFC00000 -> fault=0, pc_d=BFC00000 one edge later.
REQ-022 Misaligned and wrap cases:
- Redirect to BFC00002 -> fault with fault_pc=BFC00002.
- With MEM_BYTES=4096, sequential fetch from BFC00FFC -> the capture at BFC00FFC is valid, the capture at BFC01000 faults.
REQ-023 Reset mid-fault: assert rst while in FAULT -> next edge fault=0, pc_f=BFC00000, fetch_count=0, valid_d=0.
